sd_sector_streamer: RTL and testbench
=====================================

# sd_sector_streamer

Multi-sector read sequencer and double-buffered byte streamer that sits directly downstream of the SD-card sector reader. It issues consecutive single-sector read commands to the reader, captures each 512-byte sector into one of two RAM banks, and presents the data as a valid/ready byte stream to the consumer (FAT/file parser, audio/video sink). The reader is kept busy whenever a bank is free, so SD reads overlap stream drain.

## Interface

Parameters:
- CNT_W, 16: width of the sector-count request.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; ignored while busy=1.
- start_sector  in  32  first sector number, sampled on accepted start.
- sector_count  in  CNT_W  number of sectors, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transfer end.
- err_short  out  1  sticky; a sector completed with ≠512 bytes received. Cleared on accepted start.
- rd_start  out  1  read request to the sector reader (level, see Timing).
- rd_sector  out  32  sector number for rd_start.
- rd_busy  in  1  reader busy.
- rd_done  in  1  reader one-cycle sector-complete pulse.
- in_req  in  1  reader byte strobe.
- in_addr  in  9  byte index 0..511.
- in_byte  in  8  byte value.
- m_valid  out  1  stream valid.
- m_data  out  8  stream byte.
- m_last  out  1  with m_valid on byte 511 of the final sector.
- m_ready  in  1  consumer ready.

## Operation

- Reset: all outputs 0; both bank-full flags 0; wbank=rbank=0; issued=drained=0; FSM IDLE.
- Issue FSM: IDLE → ISSUE → WAIT_BUSY → FILL → (ISSUE | TAIL) → IDLE.
  - IDLE: on start, latch start_sector/sector_count, clear err_short, assert busy. If sector_count=0, pulse done next cycle and return to IDLE.
  - ISSUE: enter only when full[wbank]=0, issued<count and rd_busy=0. Drive rd_start=1, rd_sector=start_sector+issued (mod 2^32).
  - WAIT_BUSY: hold rd_start until rd_busy=1, then drop it.
  - FILL: each in_req writes in_byte to RAM[{wbank,in_addr}] and increments a 10-bit byte counter. On rd_done: set full[wbank], toggle wbank, issued++. If the counter ≠512, set err_short; the bank is still marked full. Next state is ISSUE if issued<count, else TAIL.
  - TAIL: wait until drained==count, then pulse done, clear busy, and go to IDLE.
- Drain side runs independently. While full[rbank]=1, stream bytes 0..511 of rbank in order. When byte 511 is accepted: clear full[rbank], toggle rbank, drained++.
- A bank written and drained in the same cycle cannot occur; the write side only targets banks with full=0.
- start while busy has no effect. There is no abort; reset is the only way to cancel.

## Timing

- Stream handshake: a transfer occurs when m_valid&m_ready. While m_valid=1 and m_ready=0, m_data and m_last are held stable.
- RAM read is synchronous, 1 cycle. A prefetch/skid register sustains 1 byte/cycle with m_ready held high.
- First m_valid occurs 2 cycles after full[rbank] sets.
- rd_start asserts no earlier than 1 cycle after the condition full[wbank]=0 and rd_busy=0 holds, and remains high until rd_busy=1 is sampled.
- The rd_done pulse and the final-byte accept of the other bank may occur in the same cycle; both updates take effect.
- done asserts the cycle after the last byte accept (m_last transfer).
- Reset mid-transfer: immediate return to reset values. Outstanding in_req/rd_done seen in IDLE are ignored.

## Structure

- Package sd_stream_pkg holds:
  - SECTOR_BYTES=512.
  - The issue-FSM state enum {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_FILL, S_TAIL}.
- Sub-module sd_bank_ram: 1024×8 simple dual-port RAM, one write port and one registered read port, inferable to a single M9K.

## Test plan

- Basic: count=1, start_sector=100, reader model sends byte i = i[7:0]^0x5A, m_ready=1 → one rd_start with rd_sector=100; 512 bytes in order; m_last on byte 511; done 1 cycle later; err_short=0.
- Backpressure and wrap: count=3, start_sector=0xFFFFFFFF, m_ready=0 initially → exactly 2 reads (0xFFFFFFFF, 0x00000000), then stall. Raise m_ready → third read (0x00000001) issues only after bank 0 drains; 1536 bytes total.
- Zero count: count=0 → done 1 cycle after start; rd_start never asserted; busy high for 1 cycle.
- Random m_ready (50%) with count=4 → output sequence matches reader data exactly, with no duplicates or drops; m_data stable during stalls.
- Short sector: model sends 500 in_req then rd_done → err_short=1 (sticky); stream still emits 512 bytes; next accepted start clears err_short.
- Reset in FILL mid-sector, then new start count=1 → outputs 0 during reset; the new transfer completes correctly. start pulsed while busy → ignored.

Source files
------------

// File: rtl/sd_stream_pkg.sv
// Shared constants and issue-FSM state type for the SD sector streamer.
package sd_stream_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_FILL,
        S_TAIL
    } issue_state_t;

endpackage

// File: rtl/sd_bank_ram.sv
// Two 512-byte sector banks in one simple dual-port RAM: a write port and a
// registered read port, shaped so it maps onto a single block RAM.
module sd_bank_ram
    import sd_stream_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [7:0] wdata,
    input  logic [9:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [2*SECTOR_BYTES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_sector_streamer.sv
// Issues consecutive sector reads into two RAM banks and drains them as a
// valid/ready byte stream, overlapping SD reads with stream consumption.
module sd_sector_streamer
    import sd_stream_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      start_sector,
    input  logic [CNT_W-1:0] sector_count,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    output logic             rd_start,
    output logic [31:0]      rd_sector,
    input  logic             rd_busy,
    input  logic             rd_done,
    input  logic             in_req,
    input  logic [8:0]       in_addr,
    input  logic [7:0]       in_byte,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready
);

    issue_state_t     state, state_next;
    logic [31:0]      base_sector;
    logic [CNT_W-1:0] count, issued, drained;
    logic [1:0]       full;
    logic             wbank, rbank;
    logic [9:0]       byte_cnt, byte_total;
    logic [8:0]       ptr, ptr_fetch;
    logic             vld, prime;
    logic             accept, can_issue, fill_done, fire, last_byte, sector_end;
    logic [7:0]       ram_rdata;

    assign accept     = start && (state == S_IDLE);
    assign can_issue  = !full[wbank] && !rd_busy;
    assign fill_done  = (state == S_FILL) && rd_done;
    assign byte_total = byte_cnt + 10'(in_req);
    assign fire       = vld && m_ready;
    assign last_byte  = (ptr == 9'(SECTOR_BYTES - 1));
    assign sector_end = fire && last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = (sector_count == '0) ? S_TAIL : S_ISSUE;
            S_ISSUE:     if (can_issue) state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (rd_busy) state_next = S_FILL;
            S_FILL:      if (rd_done) state_next = ((issued + CNT_W'(1)) < count) ? S_ISSUE : S_TAIL;
            S_TAIL:      if (drained == count) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_TAIL) && (drained == count);
    assign rd_start  = (state == S_WAIT_BUSY);
    assign rd_sector = rd_start ? (base_sector + 32'(issued)) : '0;

    // The byte counter restarts while the request is outstanding, so each sector counts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_sector <= '0;
            count       <= '0;
            issued      <= '0;
            err_short   <= 1'b0;
            wbank       <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            if (accept) begin
                base_sector <= start_sector;
                count       <= sector_count;
                issued      <= '0;
                err_short   <= 1'b0;
            end
            if (state == S_WAIT_BUSY)
                byte_cnt <= '0;
            else if ((state == S_FILL) && in_req)
                byte_cnt <= byte_cnt + 10'd1;
            if (fill_done) begin
                wbank  <= ~wbank;
                issued <= issued + CNT_W'(1);
                if (byte_total != 10'(SECTOR_BYTES)) err_short <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (fill_done)  full[wbank] <= 1'b1;
            if (sector_end) full[rbank] <= 1'b0;
        end
    end

    // Drain: prime one cycle so the RAM has read byte 0, then stream; the
    // next bank continues back-to-back only if it was already full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank   <= 1'b0;
            ptr     <= '0;
            vld     <= 1'b0;
            prime   <= 1'b0;
            drained <= '0;
        end else begin
            if (accept) drained <= '0;
            if (sector_end) begin
                ptr     <= '0;
                rbank   <= ~rbank;
                drained <= drained + CNT_W'(1);
                vld     <= full[!rbank];
                prime   <= 1'b0;
            end else if (fire) begin
                ptr <= ptr + 9'd1;
            end else if (!vld) begin
                if (prime) begin
                    vld   <= 1'b1;
                    prime <= 1'b0;
                end else if (full[rbank]) begin
                    prime <= 1'b1;
                end
            end
        end
    end

    // Holding the read address during a stall keeps m_data stable without a skid copy.
    assign ptr_fetch = fire ? (ptr + 9'd1) : ptr;

    sd_bank_ram u_ram (
        .clk   (clk),
        .we    ((state == S_FILL) && in_req),
        .waddr ({wbank, in_addr}),
        .wdata (in_byte),
        .raddr ({(sector_end ? ~rbank : rbank), ptr_fetch}),
        .rdata (ram_rdata)
    );

    assign m_valid = vld;
    assign m_data  = vld ? ram_rdata : '0;
    assign m_last  = vld && last_byte && ((drained + CNT_W'(1)) == count);

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Self-checking bench: reader and consumer models around the streamer, with
// expected reads and stream contents derived from sector numbers and counts.
module tb_sd_sector_streamer;

    localparam int CNT_W      = 16;
    localparam int RDY_ALWAYS = 0;
    localparam int RDY_NEVER  = 1;
    localparam int RDY_RANDOM = 2;

    typedef struct {
        logic [31:0] sector;
        int          count;
        int          ready_mode;
        int          bps;
        bit          gaps;
        bit          exp_err;
        bit          restart;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      start_sector = '0;
    logic [CNT_W-1:0] sector_count = '0;
    logic             busy, done, err_short, rd_start;
    logic [31:0]      rd_sector;
    logic             rd_busy = 1'b0;
    logic             rd_done = 1'b0;
    logic             in_req = 1'b0;
    logic [8:0]       in_addr = '0;
    logic [7:0]       in_byte = '0;
    logic             m_valid, m_last;
    logic [7:0]       m_data;
    logic             m_ready = 1'b0;

    sd_sector_streamer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_sector(start_sector),
        .sector_count(sector_count), .busy(busy), .done(done), .err_short(err_short),
        .rd_start(rd_start), .rd_sector(rd_sector), .rd_busy(rd_busy), .rd_done(rd_done),
        .in_req(in_req), .in_addr(in_addr), .in_byte(in_byte), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] issued_q[$];
    int          issue_got_q[$];
    logic [7:0]  got_q[$];
    int          ready_mode = RDY_ALWAYS, bps = 512, exp_total = 0;
    bit          gaps = 0, kill_reader = 0, sticky_exp = 0;
    int          done_cnt = 0, last_err = 0, stall_err = 0, done_err = 0, last_seen = 0;
    int          rd_start_cycles = 0;
    vec_t        vecs[5];

    function automatic logic [7:0] sec_byte(input logic [31:0] s, input int i);
        logic [7:0] ii;
        ii = i[7:0];
        return ii ^ 8'h5A ^ (s[7:0] - 8'd100);
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Sector reader model: answers each rd_start with busy, bytes, then rd_done.
    initial begin : reader
        logic [31:0] sec;
        forever begin
            @(posedge clk); #1;
            if (rd_start && !kill_reader) begin
                sec = rd_sector;
                issued_q.push_back(sec);
                issue_got_q.push_back(got_q.size());
                rd_busy = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < bps && !kill_reader; i++) begin
                    if (gaps)
                        while ($urandom_range(0, 3) == 0 && !kill_reader) begin
                            @(posedge clk); #1;
                        end
                    in_req  = 1'b1;
                    in_addr = i[8:0];
                    in_byte = sec_byte(sec, i);
                    @(posedge clk); #1;
                    in_req  = 1'b0;
                end
                if (!kill_reader) begin
                    rd_done = 1'b1;
                    @(posedge clk); #1;
                    rd_done = 1'b0;
                end
                rd_busy = 1'b0;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                RDY_ALWAYS: m_ready = 1'b1;
                RDY_NEVER:  m_ready = 1'b0;
                default:    m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Consumer monitor, sampled mid-cycle: collects accepted bytes and tallies protocol errors.
    initial begin : monitor
        logic       pv, pr, pl, last_fire;
        logic [7:0] pd;
        pv = 0; pr = 0; pl = 0; pd = '0; last_fire = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pr = 0; pl = 0; last_fire = 0;
            end else begin
                if (rd_start) rd_start_cycles++;
                if (done) done_cnt++;
                if (last_fire && !done) done_err++;
                if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stall_err++;
                last_fire = 0;
                if (m_valid && m_ready) begin
                    if (m_last !== (got_q.size() == exp_total - 1)) last_err++;
                    if (m_last) begin
                        last_seen++;
                        last_fire = 1;
                    end
                    got_q.push_back(m_data);
                end
                pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            end
        end
    end

    task automatic clear_monitors();
        issued_q.delete();
        issue_got_q.delete();
        got_q.delete();
        last_err = 0; stall_err = 0; done_err = 0; last_seen = 0;
    endtask

    task automatic pulse_start(input logic [31:0] sector, input int count);
        @(posedge clk); #1;
        start        = 1'b1;
        start_sector = sector;
        sector_count = CNT_W'(count);
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", longint'(done_cnt != c0), 1);
    endtask

    task automatic compare_stream(input logic [31:0] sector, input int count, input int nbytes);
        int          bad = 0;
        logic [31:0] s;
        check_output("rd_count", issued_q.size(), count);
        for (int k = 0; k < issued_q.size() && k < count; k++) begin
            s = sector + k;
            if (issued_q[k] !== s) bad++;
        end
        check_output("rd_sector", bad, 0);
        check_output("byte_count", got_q.size(), count * 512);
        bad = 0;
        for (int j = 0; j < got_q.size(); j++) begin
            s = sector + j / 512;
            if ((j % 512) < nbytes && got_q[j] !== sec_byte(s, j % 512)) bad++;
        end
        check_output("stream_data", bad, 0);
        check_output("m_last_flags", last_err, 0);
        check_output("m_last_count", last_seen, 1);
        check_output("stall_hold", stall_err, 0);
        check_output("done_after_last", done_err, 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        check_output("err_sticky_before_start", err_short, sticky_exp);
        clear_monitors();
        ready_mode = v.ready_mode;
        bps        = v.bps;
        gaps       = v.gaps;
        exp_total  = v.count * 512;
        pulse_start(v.sector, v.count);
        @(negedge clk);
        check_output("busy_after_start", busy, 1);
        check_output("err_cleared_on_start", err_short, 0);
        if (v.restart) begin
            repeat (40) @(posedge clk);
            pulse_start(32'd999, 5);
        end
        wait_done(4000 * v.count + 2000);
        @(negedge clk);
        check_output("busy_cleared", busy, 0);
        check_output("err_short", err_short, v.exp_err);
        compare_stream(v.sector, v.count, v.bps);
        sticky_exp = v.exp_err;
    endtask

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : test
        int   starts0;
        vec_t rv;

        vecs[0] = '{32'd100,        1, RDY_ALWAYS, 512, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0010,  2, RDY_ALWAYS, 512, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h1234_5678,  4, RDY_RANDOM, 512, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'd7,          1, RDY_ALWAYS, 500, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'd200,        1, RDY_RANDOM, 512, 1'b0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check_output("reset_outputs",
                     {busy, done, err_short, rd_start, m_valid, m_last, rd_sector, m_data}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

        // Zero count: done the cycle after start, busy for exactly one cycle, no read.
        clear_monitors();
        starts0 = rd_start_cycles;
        pulse_start(32'd5, 0);
        @(negedge clk);
        check_output("zero_busy", busy, 1);
        check_output("zero_done", done, 1);
        @(negedge clk);
        check_output("zero_busy_drop", busy, 0);
        check_output("zero_done_drop", done, 0);
        check_output("zero_no_rd_start", rd_start_cycles - starts0, 0);
        sticky_exp = 0;

        // Backpressure across the 32-bit sector wrap.
        clear_monitors();
        ready_mode = RDY_NEVER; bps = 512; gaps = 0; exp_total = 1536;
        pulse_start(32'hFFFF_FFFF, 3);
        repeat (1500) @(negedge clk);
        check_output("bp_reads_stalled", issued_q.size(), 2);
        check_output("bp_no_bytes", got_q.size(), 0);
        ready_mode = RDY_ALWAYS;
        wait_done(6000);
        compare_stream(32'hFFFF_FFFF, 3, 512);
        if (issue_got_q.size() == 3)
            check_output("bp_third_after_drain", longint'(issue_got_q[2] >= 512), 1);

        for (int r = 0; r < 3; r++) begin
            rv.sector     = $urandom;
            rv.count      = $urandom_range(1, 3);
            rv.ready_mode = ($urandom_range(0, 1) == 0) ? RDY_ALWAYS : RDY_RANDOM;
            rv.bps        = 512;
            rv.gaps       = 1'($urandom_range(0, 1));
            rv.exp_err    = 1'b0;
            rv.restart    = 1'($urandom_range(0, 1));
            apply_stimulus(rv);
        end

        // Reset in the middle of a fill, then stray reader strobes while idle.
        clear_monitors();
        ready_mode = RDY_ALWAYS; bps = 512; gaps = 0; exp_total = 1024;
        pulse_start(32'd50, 2);
        repeat (300) @(posedge clk);
        #1;
        kill_reader = 1'b1;
        rst_n       = 1'b0;
        @(negedge clk);
        check_output("reset_mid_fill_outputs",
                     {busy, done, err_short, rd_start, m_valid, m_last, rd_sector, m_data}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        kill_reader = 1'b0;
        in_req = 1'b1; in_addr = '0; in_byte = 8'hFF; rd_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_req = 1'b0; rd_done = 1'b0;
        @(negedge clk);
        check_output("idle_ignores_reader", {busy, err_short, m_valid}, 0);
        sticky_exp = 0;
        apply_stimulus('{32'd300, 1, RDY_ALWAYS, 512, 1'b0, 1'b0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
